// File: rtl/dot_collect_25_pkg.sv
// Shared constants and state encoding for the dot_collect_25 slice collector.
package dot_collect_25_pkg;

  // Width of one upstream dot-product result (two's complement).
  localparam int unsigned DataLen = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StGap  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/dot_collect_25_relu_sat.sv
// Combinational clamp of a signed value to zero when negative.
// Active only when DOT_COLLECT_RELU_EN is defined; otherwise a pass-through.
module dot_collect_25_relu_sat #(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

`ifdef DOT_COLLECT_RELU_EN
  assign q = d[Width-1] ? '0 : d;
`else
  assign q = d;
`endif

endmodule

// File: rtl/dot_collect_25.sv
// Steps the upstream slice select, collects one scalar per slice into a flat slot
// buffer and hands the packed vector downstream. Optional ReLU via DOT_COLLECT_RELU_EN.
module dot_collect_25
  import dot_collect_25_pkg::*;
#(
  parameter int unsigned NCS = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dot_valid,
  input  logic [DataLen-1:0]     dot_q,
  output logic [3:0]             cs,
  output logic                   load,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NCS*DataLen-1:0] out_data
);

  state_e                 state_q, state_d;
  logic [3:0]             cs_q, cs_d;
  logic                   first_q, first_d;
  logic                   load_q, busy_q, out_valid_q;
  logic [NCS*DataLen-1:0] slots_q, slots_d;
  logic [DataLen-1:0]     relu_q;
  logic                   capture;
  logic                   last_slice;

  dot_collect_25_relu_sat #(
    .Width (DataLen)
  ) u_relu_sat (
    .d (dot_q),
    .q (relu_q)
  );

  // The first LOAD cycle is blind so a valid left over from the previous slice is dropped.
  assign capture    = (state_q == StLoad) && dot_valid && !first_q;
  assign last_slice = (cs_q == 4'(NCS - 1));

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    first_d = first_q;
    slots_d = slots_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          cs_d    = '0;
          first_d = 1'b1;
        end
      end
      StLoad: begin
        first_d = 1'b0;
        if (capture) begin
          slots_d[cs_q*DataLen +: DataLen] = relu_q;
          state_d = last_slice ? StDone : StGap;
        end
      end
      StGap: begin
        cs_d    = cs_q + 4'd1;
        first_d = 1'b1;
        state_d = StLoad;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          cs_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cs_q        <= '0;
      first_q     <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      slots_q     <= '0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      first_q     <= first_d;
      // Outputs are flopped from the next state so they track state_q exactly.
      load_q      <= (state_d == StLoad);
      busy_q      <= (state_d != StIdle);
      out_valid_q <= (state_d == StDone);
      slots_q     <= slots_d;
    end
  end

  assign cs        = cs_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = slots_q;

endmodule

// File: tb/tb_dot_collect_25.sv
// Self-checking bench for dot_collect_25 with a fixed-latency upstream model and
// a scoreboard of expected slot values.
module tb_dot_collect_25;
  import dot_collect_25_pkg::*;

  localparam int unsigned NCS = 12;
  localparam int unsigned DL  = DataLen;
  localparam int          LAT = 12;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                dot_valid;
  logic [DL-1:0]       dot_q;
  logic [3:0]          cs;
  logic                load;
  logic                busy;
  logic                out_valid;
  logic                out_ready;
  logic [NCS*DL-1:0]   out_data;

  int errors;
  int checks;

  // Upstream model controls
  int  base;
  int  neg_slice;
  bit  stale_mode;
  int  cnt;
  bit  m_prev_load;

  logic [DL-1:0] exp_q[$];
  int            cs_seq[$];
  int            gap_seq[$];
  int            low_cnt;
  bit            mon_prev_load;

  dot_collect_25 #(
    .NCS (NCS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dot_valid (dot_valid),
    .dot_q     (dot_q),
    .cs        (cs),
    .load      (load),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DL-1:0] slice_value(input int i);
    if (i == neg_slice) return 16'hFFFB;
    return DL'(base + i);
  endfunction

  function automatic logic [DL-1:0] relu_model(input logic [DL-1:0] v);
`ifdef DOT_COLLECT_RELU_EN
    if (v[DL-1]) return '0;
`endif
    return v;
  endfunction

  // Upstream: restarts on each load rise, returns its result LAT cycles later and
  // holds it while load stays high. In stale mode it keeps a garbage valid asserted
  // whenever load is low and during the first load-high cycle.
  always @(negedge clk) begin
    logic [DL-1:0] v;
    if (!rst_n) begin
      cnt         = 0;
      m_prev_load = 1'b0;
      dot_valid   = 1'b0;
      dot_q       = '0;
    end else begin
      if (load && !m_prev_load) begin
        cnt       = LAT;
        dot_valid = stale_mode;
        dot_q     = '1;
      end else if (load && cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          v         = slice_value(int'(cs));
          dot_valid = 1'b1;
          dot_q     = v;
          exp_q.push_back(relu_model(v));
        end else begin
          dot_valid = 1'b0;
        end
      end else if (!load) begin
        dot_valid = stale_mode;
        dot_q     = stale_mode ? '1 : '0;
      end
      m_prev_load = load;
    end
  end

  // Records cs at each load rise and the number of load-low cycles before it.
  always @(negedge clk) begin
    if (load && !mon_prev_load) begin
      cs_seq.push_back(int'(cs));
      gap_seq.push_back(low_cnt);
    end
    low_cnt       = load ? 0 : low_cnt + 1;
    mon_prev_load = load;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 4'd0) begin errors++; $display("FAIL reset_cs got %0d want 0", cs); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b want 0", load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ok;
    logic [DL-1:0] e;
    base = 100; neg_slice = -1; stale_mode = 1'b0; out_ready = 1'b1;
    cs_seq.delete(); gap_seq.delete();
    pulse_start();
    checks++;
    if (load !== 1'b1 || cs !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL basic_start load=%b cs=%0d busy=%b want 1/0/1", load, cs, busy);
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done timeout got 0 want out_valid"); end
    checks++;
    if (exp_q.size() != NCS) begin errors++; $display("FAIL basic_sb_size got %0d want %0d", exp_q.size(), NCS); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL basic_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    checks++;
    if (cs_seq.size() != NCS) begin errors++; $display("FAIL basic_cs_count got %0d want %0d", cs_seq.size(), NCS); end
    for (int i = 0; i < cs_seq.size(); i++) begin
      checks++;
      if (cs_seq[i] != i) begin errors++; $display("FAIL basic_cs_seq%0d got %0d want %0d", i, cs_seq[i], i); end
      if (i > 0) begin
        checks++;
        if (gap_seq[i] != 1) begin errors++; $display("FAIL basic_gap%0d got %0d want 1", i, gap_seq[i]); end
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_drop out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_stale();
    bit ok;
    logic [DL-1:0] e;
    base = 0; neg_slice = -1; stale_mode = 1'b1; out_ready = 1'b1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stale_done timeout got 0 want out_valid"); end
    checks++;
    if (exp_q.size() != NCS) begin errors++; $display("FAIL stale_sb_size got %0d want %0d", exp_q.size(), NCS); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL stale_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    stale_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_relu();
    bit ok;
    logic [DL-1:0] e;
    logic [DL-1:0] want3;
`ifdef DOT_COLLECT_RELU_EN
    want3 = 16'h0000;
`else
    want3 = 16'hFFFB;
`endif
    base = 400; neg_slice = 3; out_ready = 1'b1;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL relu_done timeout got 0 want out_valid"); end
    checks++;
    if (out_data[3*DL +: DL] !== want3) begin
      errors++; $display("FAIL relu_slot3 got %h want %h", out_data[3*DL +: DL], want3);
    end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL relu_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    neg_slice = -1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DL-1:0] e;
    logic [NCS*DL-1:0] snap;
    base = 200; out_ready = 1'b0;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done timeout got 0 want out_valid"); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL bp_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    snap = out_data;
    for (int k = 0; k < 20; k++) begin
      start = (k % 5 == 0);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== snap) begin
        errors++; $display("FAIL bp_hold%0d out_valid=%b data=%h want 1 and %h", k, out_valid, out_data, snap);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue busy got %b want 0", busy); end
  endtask

  task automatic test_handshake_start();
    bit ok;
    logic [DL-1:0] e;
    base = 300; out_ready = 1'b0;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_done timeout got 0 want out_valid"); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL hs_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || load !== 1'b0) begin
      errors++; $display("FAIL hs_same_edge out_valid=%b busy=%b load=%b want 0/0/0", out_valid, busy, load);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || load !== 1'b1 || cs !== 4'd0) begin
      errors++; $display("FAIL hs_next_start busy=%b load=%b cs=%0d want 1/1/0", busy, load, cs);
    end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hs_run2 timeout got 0 want out_valid"); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL hs_run2_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit ok;
    logic [DL-1:0] e;
    base = 600; out_ready = 1'b1;
    pulse_start();
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (load && cs == 4'd5) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_reach_slice5 timeout got 0 want 1"); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (load !== 1'b0 || cs !== 4'd0 || busy !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL mid_abort load=%b cs=%0d busy=%b data=%h want 0/0/0/0", load, cs, busy, out_data);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = 700;
    pulse_start();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_rerun timeout got 0 want out_valid"); end
    checks++;
    if (exp_q.size() != NCS) begin errors++; $display("FAIL mid_sb_size got %0d want %0d", exp_q.size(), NCS); end
    for (int i = 0; i < NCS && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_data[i*DL +: DL] !== e) begin
        errors++; $display("FAIL mid_slot%0d got %h want %h", i, out_data[i*DL +: DL], e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    errors = 0; checks = 0;
    start = 1'b0; out_ready = 1'b1; rst_n = 1'b0;
    base = 0; neg_slice = -1; stale_mode = 1'b0;
    low_cnt = 0; mon_prev_load = 1'b0;
    test_reset();
    test_basic();
    test_stale();
    test_relu();
    test_backpressure();
    test_handshake_start();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_collect_25.md
# dot_collect_25

Sequencer and collector directly downstream of the per-channel dot-product stage. Steps the weight-slice select `cs` through every slice and pulses `load` so the upstream stage restarts for each slice. Captures each scalar result on the upstream `valid`, optionally applies ReLU, and stores it in a slot buffer. Once all slices are collected, presents the packed vector to the next layer with a valid/ready handshake.

## Interface
- `NCS`, default 12: number of slices collected per run; legal range 1..16.
- `clk  in  1`: clock; all state updates on its rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `start  in  1`: run request; sampled only in IDLE.
- `dot_valid  in  1`: upstream result valid.
- `dot_q  in  `data_len`: upstream result, two's complement.
- `cs  out  4`: slice select driven to the upstream stage.
- `load  out  1`: upstream load; the upstream restarts on each 0→1 edge.
- `busy  out  1`: high in every state except IDLE.
- `out_valid  out  1`: packed result available.
- `out_ready  in  1`: consumer accepts the packed result.
- `out_data  out  NCS*`data_len`: slot i occupies bits [i*`data_len +: `data_len].

## Operation
- States:
  - IDLE: `load`=0, `cs`=0. `start`=1 → LOAD.
  - LOAD: `load`=1, `cs`=slot index. The capture condition is `dot_valid`=1 while `first`=0. `first` is a 1-bit flag set on entry to LOAD and cleared after one cycle. On capture, write `dot_q` (after ReLU, if enabled) to slot[`cs`].
    - If `cs`==NCS-1 → DONE.
    - Otherwise → GAP.
  - GAP: `load`=0 for exactly one cycle. `cs` increments by 1, then → LOAD. The low cycle guarantees the upstream sees a fresh load edge and re-initialises.
  - DONE: `load`=0, `out_valid`=1, `out_data` stable. `out_ready`=1 → IDLE.
- `dot_valid` is ignored in IDLE, GAP, DONE and in the first LOAD cycle. This discards stale upstream valids from the previous slice.
- Slots are never written in any state other than LOAD. Slot contents persist after DONE until overwritten by the next run.
- `start` is ignored while `busy`=1; it is not queued.
- `cs` never wraps: the counter stops at NCS-1, and NCS=16 uses the full 4-bit range.
- There is no timeout. If the upstream never asserts `dot_valid`, the block stays in LOAD until reset.

## Timing
- Reset values:
  - state=IDLE, `cs`=0, `load`=0, `busy`=0, `out_valid`=0, `first`=0.
  - All slots=0, so `out_data`=0.
- Reset takes effect asynchronously; release is synchronous to `clk`.
- All outputs are registered; no combinational input→output paths.
- `start` seen at edge k → `load`=1, `cs`=0, `busy`=1 from edge k+1.
- Capture edge for slice i → `load`=0 in the next cycle (GAP). `load`=1 with `cs`=i+1 one cycle after that.
- For the last slice, capture edge → `out_valid`=1 in the next cycle.
- Per-slice overhead is 2 cycles (first LOAD cycle plus GAP) on top of the upstream latency.
- Handshake: transfer occurs on an edge where `out_valid`&&`out_ready`. `out_valid` drops in the following cycle and state returns to IDLE.
  - `start` high on that same edge is ignored, because it is only sampled in IDLE.
  - A new run therefore starts, at the earliest, on the edge after IDLE is re-entered.
- Reset asserted mid-run aborts immediately: `load` drops and partial slots are cleared.

## Configuration
- `DOT_COLLECT_RELU_EN` defined: a captured value with MSB=1 is stored as 0; non-negative values are stored unchanged.
- Not defined: `dot_q` is stored bit-exact.
- Timing and the handshake are identical in both builds.

## Structure
- `data_len` comes from the existing shared `num_data.v` include. No new global constants.
- Add to the shared include: state encodings (IDLE=0, LOAD=1, GAP=2, DONE=3), as 2-bit localparams.
- One natural sub-module, `relu_sat`: a combinational `data_len`-wide clamp. It passes data through when `DOT_COLLECT_RELU_EN` is undefined.
- The slot buffer is a flat register vector inside the top module; no RAM inference.

## Test plan
- NCS=12, upstream model with 12-cycle latency returning value 100+i for slice i; `start` 1 cycle; `out_ready`=1 → `out_valid` rises once, slot i=100+i. `cs` sequence 0..11, each step preceded by exactly one `load`=0 cycle.
- Stale valid: the model holds `dot_valid`=1 through GAP and the first LOAD cycle, with wrong data 0xFF..F → stale data never captured, slots correct.
- RELU: slice 3 returns -5 → slot 3=0 with `DOT_COLLECT_RELU_EN` defined; slot 3=-5 without it.
- Backpressure: `out_ready`=0 for 20 cycles → `out_valid` and `out_data` stable. `start` pulses during the wait are ignored. `out_ready`=1 → `out_valid`=0 next cycle.
- Handshake and `start` on the same edge → no run begins. `start` one cycle later → run begins with `cs`=0.
- `rst_n` low during slice 5 → `load`=0, `cs`=0, `busy`=0, `out_data`=0 immediately. The next run completes normally.
